// File: rtl/cam_frame_writer.sv
// Camera pixel-stream writer: packs 8-bit pixels four to a 32-bit word and
// writes one frame into the memory-mapped frame buffer starting at BASE_ADDR.
module cam_frame_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h0005_0000,
  parameter int unsigned FRAME_W   = 160,
  parameter int unsigned FRAME_H   = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sof,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        sync_err
);

  localparam int unsigned NUM_WORDS = (FRAME_W * FRAME_H) / 4;
  localparam int unsigned WCW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     pix_cnt, pix_cnt_nxt;
  logic [WCW-1:0] word_cnt, word_cnt_nxt;
  logic [23:0]    word_buf, word_buf_nxt;
  logic           pix_ready_nxt, mem_we_nxt, busy_nxt, done_nxt, sync_err_nxt;
  logic [31:0]    mem_addr_nxt, mem_wdata_nxt;
  logic           accept;

  assign accept = pix_valid & pix_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = WAIT_SOF;
      WAIT_SOF: if (accept && sof) state_nxt = CAPTURE;
      CAPTURE:  if (accept && !sof && (pix_cnt == 2'd3) && (word_cnt == LAST_WORD))
                  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; registered below
  always_comb begin
    pix_ready_nxt = (state_nxt == WAIT_SOF) || (state_nxt == CAPTURE);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state == DONE);
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    sync_err_nxt  = sync_err;
    pix_cnt_nxt   = pix_cnt;
    word_cnt_nxt  = word_cnt;
    word_buf_nxt  = word_buf;

    if ((state == IDLE) && start) sync_err_nxt = 1'b0;

    // sof always restarts the frame; mid-frame it also flags a sync loss
    if (accept && sof) begin
      word_buf_nxt = {16'h0000, pix_data};
      pix_cnt_nxt  = 2'd1;
      word_cnt_nxt = '0;
      if (state == CAPTURE) sync_err_nxt = 1'b1;
    end else if (accept && (state == CAPTURE)) begin
      if (pix_cnt == 2'd3) begin
        mem_we_nxt    = 1'b1;
        mem_wdata_nxt = {pix_data, word_buf};
        mem_addr_nxt  = BASE_ADDR + (32'(word_cnt) << 2);
        pix_cnt_nxt   = 2'd0;
        word_cnt_nxt  = (word_cnt == LAST_WORD) ? '0 : word_cnt + WCW'(1);
      end else begin
        case (pix_cnt)
          2'd0:    word_buf_nxt[7:0]   = pix_data;
          2'd1:    word_buf_nxt[15:8]  = pix_data;
          default: word_buf_nxt[23:16] = pix_data;
        endcase
        pix_cnt_nxt = pix_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sync_err  <= 1'b0;
      pix_cnt   <= '0;
      word_cnt  <= '0;
      word_buf  <= '0;
    end else begin
      pix_ready <= pix_ready_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      sync_err  <= sync_err_nxt;
      pix_cnt   <= pix_cnt_nxt;
      word_cnt  <= word_cnt_nxt;
      word_buf  <= word_buf_nxt;
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed-vector bench for cam_frame_writer on a 4x2 frame (two words per frame).
module tb_cam_frame_writer;

  localparam logic [31:0] A0 = 32'h0005_0000;
  localparam logic [31:0] A1 = 32'h0005_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sof, pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready, mem_we, busy, done, sync_err;
  logic [31:0] mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
  } outs_t;

  typedef struct packed {
    logic       start;
    logic       sof;
    logic       valid;
    logic [7:0] data;
    outs_t      exp;
  } vec_t;

  vec_t vecs[$];

  cam_frame_writer #(
    .BASE_ADDR(32'h0005_0000),
    .FRAME_W  (4),
    .FRAME_H  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sof      (sof),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .pix_ready(pix_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic sf, input logic vl,
                              input logic [7:0] d, input logic rdy, input logic we,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic bs, input logic dn, input logic er);
    vec_t v;
    v.start = st; v.sof = sf; v.valid = vl; v.data = d;
    v.exp.ready = rdy; v.exp.we = we; v.exp.addr = a; v.exp.wdata = wd;
    v.exp.busy = bs; v.exp.done = dn; v.exp.err = er;
    return v;
  endfunction

  task automatic check_outs(input string name, input outs_t exp);
    outs_t act;
    act = '{ready: pix_ready, we: mem_we, addr: mem_addr, wdata: mem_wdata,
             busy: busy, done: done, err: sync_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b, expected rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b",
               name, act.ready, act.we, act.addr, act.wdata, act.busy, act.done, act.err,
               exp.ready, exp.we, exp.addr, exp.wdata, exp.busy, exp.done, exp.err);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    start     = v.start;
    sof       = v.sof;
    pix_valid = v.valid;
    pix_data  = v.data;
    @(posedge clk);
    #1;
    check_outs(name, v.exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;

    // Full-rate frame
    vecs.push_back(mk(1,0,0,8'h00, 1,0,32'h0,32'h0,1,0,0));
    vecs.push_back(mk(0,1,1,8'h11, 1,0,32'h0,32'h0,1,0,0));
    vecs.push_back(mk(0,0,1,8'h22, 1,0,32'h0,32'h0,1,0,0));
    vecs.push_back(mk(0,0,1,8'h33, 1,0,32'h0,32'h0,1,0,0));
    vecs.push_back(mk(0,0,1,8'h44, 1,1,A0,32'h44332211,1,0,0));
    vecs.push_back(mk(0,0,1,8'h55, 1,0,A0,32'h44332211,1,0,0));
    vecs.push_back(mk(0,0,1,8'h66, 1,0,A0,32'h44332211,1,0,0));
    vecs.push_back(mk(0,0,1,8'h77, 1,0,A0,32'h44332211,1,0,0));
    vecs.push_back(mk(0,0,1,8'h88, 0,1,A1,32'h88776655,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,A1,32'h88776655,0,1,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,A1,32'h88776655,0,0,0));
    // Frame with valid gaps (including an unqualified sof)
    vecs.push_back(mk(1,0,0,8'h00, 1,0,A1,32'h88776655,1,0,0));
    vecs.push_back(mk(0,1,1,8'hC1, 1,0,A1,32'h88776655,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 1,0,A1,32'h88776655,1,0,0));
    vecs.push_back(mk(0,0,1,8'hC2, 1,0,A1,32'h88776655,1,0,0));
    vecs.push_back(mk(0,0,1,8'hC3, 1,0,A1,32'h88776655,1,0,0));
    vecs.push_back(mk(0,1,0,8'hFF, 1,0,A1,32'h88776655,1,0,0));
    vecs.push_back(mk(0,0,1,8'hC4, 1,1,A0,32'hC4C3C2C1,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 1,0,A0,32'hC4C3C2C1,1,0,0));
    vecs.push_back(mk(0,0,1,8'hC5, 1,0,A0,32'hC4C3C2C1,1,0,0));
    vecs.push_back(mk(0,0,1,8'hC6, 1,0,A0,32'hC4C3C2C1,1,0,0));
    vecs.push_back(mk(0,0,1,8'hC7, 1,0,A0,32'hC4C3C2C1,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 1,0,A0,32'hC4C3C2C1,1,0,0));
    vecs.push_back(mk(0,0,1,8'hC8, 0,1,A1,32'hC8C7C6C5,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,A1,32'hC8C7C6C5,0,1,0));
    // Pixels before sof are discarded
    vecs.push_back(mk(1,0,0,8'h00, 1,0,A1,32'hC8C7C6C5,1,0,0));
    vecs.push_back(mk(0,0,1,8'hAA, 1,0,A1,32'hC8C7C6C5,1,0,0));
    vecs.push_back(mk(0,0,1,8'hBB, 1,0,A1,32'hC8C7C6C5,1,0,0));
    vecs.push_back(mk(0,1,1,8'h01, 1,0,A1,32'hC8C7C6C5,1,0,0));
    vecs.push_back(mk(0,0,1,8'h02, 1,0,A1,32'hC8C7C6C5,1,0,0));
    vecs.push_back(mk(0,0,1,8'h03, 1,0,A1,32'hC8C7C6C5,1,0,0));
    vecs.push_back(mk(0,0,1,8'h04, 1,1,A0,32'h04030201,1,0,0));
    vecs.push_back(mk(0,0,1,8'h05, 1,0,A0,32'h04030201,1,0,0));
    vecs.push_back(mk(0,0,1,8'h06, 1,0,A0,32'h04030201,1,0,0));
    vecs.push_back(mk(0,0,1,8'h07, 1,0,A0,32'h04030201,1,0,0));
    vecs.push_back(mk(0,0,1,8'h08, 0,1,A1,32'h08070605,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,A1,32'h08070605,0,1,0));
    // sof on the 6th pixel: resync and rewrite from word 0
    vecs.push_back(mk(1,0,0,8'h00, 1,0,A1,32'h08070605,1,0,0));
    vecs.push_back(mk(0,1,1,8'h10, 1,0,A1,32'h08070605,1,0,0));
    vecs.push_back(mk(0,0,1,8'h20, 1,0,A1,32'h08070605,1,0,0));
    vecs.push_back(mk(0,0,1,8'h30, 1,0,A1,32'h08070605,1,0,0));
    vecs.push_back(mk(0,0,1,8'h40, 1,1,A0,32'h40302010,1,0,0));
    vecs.push_back(mk(0,0,1,8'h50, 1,0,A0,32'h40302010,1,0,0));
    vecs.push_back(mk(0,1,1,8'h60, 1,0,A0,32'h40302010,1,0,1));
    vecs.push_back(mk(0,0,1,8'h61, 1,0,A0,32'h40302010,1,0,1));
    vecs.push_back(mk(0,0,1,8'h62, 1,0,A0,32'h40302010,1,0,1));
    vecs.push_back(mk(0,0,1,8'h63, 1,1,A0,32'h63626160,1,0,1));
    vecs.push_back(mk(0,0,1,8'h64, 1,0,A0,32'h63626160,1,0,1));
    vecs.push_back(mk(0,0,1,8'h65, 1,0,A0,32'h63626160,1,0,1));
    vecs.push_back(mk(0,0,1,8'h66, 1,0,A0,32'h63626160,1,0,1));
    vecs.push_back(mk(0,0,1,8'h67, 0,1,A1,32'h67666564,1,0,1));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,A1,32'h67666564,0,1,1));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,A1,32'h67666564,0,0,1));
    // start clears sync_err; start while busy/done is ignored
    vecs.push_back(mk(1,0,0,8'h00, 1,0,A1,32'h67666564,1,0,0));
    vecs.push_back(mk(1,0,0,8'h00, 1,0,A1,32'h67666564,1,0,0));
    vecs.push_back(mk(0,1,1,8'hA1, 1,0,A1,32'h67666564,1,0,0));
    vecs.push_back(mk(1,0,1,8'hA2, 1,0,A1,32'h67666564,1,0,0));
    vecs.push_back(mk(0,0,1,8'hA3, 1,0,A1,32'h67666564,1,0,0));
    vecs.push_back(mk(1,0,1,8'hA4, 1,1,A0,32'hA4A3A2A1,1,0,0));
    vecs.push_back(mk(0,0,1,8'hA5, 1,0,A0,32'hA4A3A2A1,1,0,0));
    vecs.push_back(mk(0,0,1,8'hA6, 1,0,A0,32'hA4A3A2A1,1,0,0));
    vecs.push_back(mk(0,0,1,8'hA7, 1,0,A0,32'hA4A3A2A1,1,0,0));
    vecs.push_back(mk(0,0,1,8'hA8, 0,1,A1,32'hA8A7A6A5,1,0,0));
    vecs.push_back(mk(1,0,1,8'hFF, 0,0,A1,32'hA8A7A6A5,0,1,0));
    vecs.push_back(mk(0,0,1,8'hEE, 0,0,A1,32'hA8A7A6A5,0,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,A1,32'hA8A7A6A5,0,0,0));

    #2;
    check_outs("reset_state", '0);
    #20;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("row%0d", i));

    // Asynchronous reset in the middle of a frame
    apply(mk(1,0,0,8'h00, 1,0,A1,32'hA8A7A6A5,1,0,0), "rst_seq_start");
    apply(mk(0,1,1,8'h31, 1,0,A1,32'hA8A7A6A5,1,0,0), "rst_seq_p0");
    apply(mk(0,0,1,8'h32, 1,0,A1,32'hA8A7A6A5,1,0,0), "rst_seq_p1");
    start = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", '0);
    #3;
    rst_n = 1'b1;
    apply(mk(0,0,0,8'h00, 0,0,32'h0,32'h0,0,0,0), "post_reset_idle");
    apply(mk(0,0,1,8'h33, 0,0,32'h0,32'h0,0,0,0), "post_reset_pix");
    apply(mk(1,0,0,8'h00, 1,0,32'h0,32'h0,1,0,0), "post_reset_start");
    apply(mk(0,1,1,8'h34, 1,0,32'h0,32'h0,1,0,0), "post_reset_p0");
    apply(mk(0,0,1,8'h35, 1,0,32'h0,32'h0,1,0,0), "post_reset_p1");
    apply(mk(0,0,1,8'h36, 1,0,32'h0,32'h0,1,0,0), "post_reset_p2");
    apply(mk(0,0,1,8'h37, 1,1,A0,32'h37363534,1,0,0), "post_reset_w0");
    apply(mk(0,0,1,8'h38, 1,0,A0,32'h37363534,1,0,0), "post_reset_p4");
    apply(mk(0,0,1,8'h39, 1,0,A0,32'h37363534,1,0,0), "post_reset_p5");
    apply(mk(0,0,1,8'h3A, 1,0,A0,32'h37363534,1,0,0), "post_reset_p6");
    apply(mk(0,0,1,8'h3B, 0,1,A1,32'h3B3A3938,1,0,0), "post_reset_w1");
    apply(mk(0,0,0,8'h00, 0,0,A1,32'h3B3A3938,0,1,0), "post_reset_done");
    apply(mk(0,0,0,8'h00, 0,0,A1,32'h3B3A3938,0,0,0), "post_reset_idle2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
